// File: rtl/switch_input_ctrl.sv
// switch_input_ctrl: Avalon-MM slave for the board slide-switch/key port.
// Each input bit is synchronised and debounced, and its accepted edges are
// latched into a W1C edge-capture register. A maskable level interrupt is
// raised from that register.
//
// Optional feature macro: SWITCH_IRQ_EN
//   defined   -> IRQMASK register and registered irq output are implemented
//   undefined -> irq tied 0, IRQMASK reads 0 and ignores writes; EDGECAP
//                still captures edges and can be polled
//
// Ports
//   clk         system clock, rising edge
//   reset       synchronous active-high reset
//   chipselect  Avalon slave select
//   address     word address: 0 DATA, 1 IRQMASK, 2 RAW, 3 EDGECAP
//   read/write  strobes, qualified by chipselect
//   writedata   32-bit write data
//   readdata    registered read data, 1-cycle latency, zero-extended
//   in_port     raw asynchronous switch inputs [WIDTH-1:0]
//   irq         registered active-high interrupt

// Per-bit lane: 2-FF synchroniser, debounce counter, edge select and the
// edge-capture bit for that input.
module switch_input_lane #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16,
  parameter int EDGE_MODE       = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  input  logic cap_clr,
  output logic sync,
  output logic stable,
  output logic cap
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic [CNT_W-1:0] cnt;
  logic             flip;
  logic             edge_hit;

  // The counter only runs while sync disagrees with stable, so reaching LAST
  // means DEBOUNCE_CYCLES consecutive disagreeing samples including this one.
  assign flip = (sync != stable) && (cnt == LAST);

  always_comb begin
    edge_hit = 1'b0;
    case (EDGE_MODE)
      0:       edge_hit = flip & sync;
      1:       edge_hit = flip & ~sync;
      default: edge_hit = flip;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1     <= 1'b0;
      sync   <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
      cap    <= 1'b0;
    end else begin
      s1   <= raw;
      sync <= s1;
      if (sync == stable) begin
        cnt <= '0;
      end else if (flip) begin
        stable <= sync;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      // A new edge in the same cycle as a W1C keeps the bit set.
      cap <= (cap & ~cap_clr) | edge_hit;
    end
  end
endmodule

module switch_input_ctrl #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16,
  parameter int EDGE_MODE       = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              chipselect,
  input  logic [1:0]        address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [WIDTH-1:0]  in_port,
  output logic              irq
);
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] edgecap;
  logic [WIDTH-1:0] cap_clr;
  logic [WIDTH-1:0] mask;
  logic             wr;
  logic             rd;
  logic             unused_wd;

  assign wr        = chipselect & write;
  assign rd        = chipselect & read;
  assign cap_clr   = (wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
  assign unused_wd = &{1'b0, writedata};

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    switch_input_lane #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W),
      .EDGE_MODE      (EDGE_MODE)
    ) u_lane (
      .clk    (clk),
      .reset  (reset),
      .raw    (in_port[i]),
      .cap_clr(cap_clr[i]),
      .sync   (sync[i]),
      .stable (stable[i]),
      .cap    (edgecap[i])
    );
  end

`ifdef SWITCH_IRQ_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      mask <= '0;
      irq  <= 1'b0;
    end else begin
      if (wr && address == 2'd1) mask <= writedata[WIDTH-1:0];
      irq <= |(edgecap & mask);
    end
  end
`else
  assign mask = '0;
  assign irq  = 1'b0;
`endif

  // Reads sample pre-edge register values, so a same-cycle write to the
  // addressed register is not visible until the next read.
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= '0;
    end else if (rd) begin
      case (address)
        2'd0:    readdata <= 32'(stable);
        2'd1:    readdata <= 32'(mask);
        2'd2:    readdata <= 32'(sync);
        default: readdata <= 32'(edgecap);
      endcase
    end
  end
endmodule

// File: tb/tb_switch_input_ctrl.sv
module tb_switch_input_ctrl;
  localparam int W  = 4;
  localparam int DC = 8;
`ifdef SWITCH_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, cs, read, write, irq;
  logic [1:0]  address;
  logic [31:0] writedata, readdata;
  logic [W-1:0] in_port;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [W-1:0]  m_s1, m_s2, m_stable, m_cap, m_mask;
  logic [DC-1:0] m_hist [W];
  logic [31:0]   m_rd;
  logic          m_irq;

  always #5 clk = ~clk;

  switch_input_ctrl #(.WIDTH(W), .DEBOUNCE_CYCLES(DC), .CNT_W(16), .EDGE_MODE(0)) dut (
    .clk(clk), .reset(reset), .chipselect(cs), .address(address), .read(read),
    .write(write), .writedata(writedata), .readdata(readdata), .in_port(in_port), .irq(irq)
  );

  // Model: a bit is accepted once the last DC synchronised samples all
  // disagree with the current debounced value.
  task automatic model_update();
    logic [W-1:0] nstab, ev, clr;
    logic [31:0]  rdn;
    logic         irqn;
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_stable = '0; m_cap = '0; m_mask = '0;
      m_rd = '0; m_irq = 1'b0;
      for (int i = 0; i < W; i++) m_hist[i] = '0;
      return;
    end
    rdn = m_rd;
    if (cs && read) begin
      case (address)
        2'd0: rdn = 32'(m_stable);
        2'd1: rdn = 32'(m_mask);
        2'd2: rdn = 32'(m_s2);
        default: rdn = 32'(m_cap);
      endcase
    end
    irqn  = IRQ_EN && (|(m_cap & m_mask));
    nstab = m_stable;
    ev    = '0;
    for (int i = 0; i < W; i++) begin
      m_hist[i] = {m_hist[i][DC-2:0], m_s2[i]};
      if (m_hist[i] == {DC{~m_stable[i]}}) begin
        nstab[i] = ~m_stable[i];
        ev[i]    = nstab[i];
      end
    end
    clr   = (cs && write && address == 2'd3) ? writedata[W-1:0] : '0;
    m_cap = (m_cap & ~clr) | ev;
    if (IRQ_EN && cs && write && address == 2'd1) m_mask = writedata[W-1:0];
    m_s2 = m_s1; m_s1 = in_port; m_stable = nstab; m_rd = rdn; m_irq = irqn;
  endtask

  // Inputs change only at negedge; the model sees the same values the DUT does.
  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    cs = 0; read = 0; write = 0; address = 0; writedata = 0;
  endtask

  task automatic do_read(input logic [1:0] a, output logic [31:0] d);
    cs = 1; read = 1; address = a;
    step();
    d = readdata;
    idle();
  endtask

  task automatic do_write(input logic [1:0] a, input logic [31:0] v);
    cs = 1; write = 1; address = a; writedata = v;
    step();
    idle();
  endtask

  task automatic test_reset();
    logic [31:0] d;
    int first_f;
    idle();
    reset = 1; in_port = 4'hF;
    repeat (3) step();
    checks++; if (readdata !== 32'h0) begin failures++; $display("FAIL reset_readdata got=%h exp=0", readdata); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
    reset = 0;
    first_f = -1;
    for (int k = 0; k < 15; k++) begin
      cs = 1; read = 1; address = 2'd0;
      step();
      checks++; if (readdata !== m_rd) begin failures++; $display("FAIL reset_data_k%0d got=%h exp=%h", k, readdata, m_rd); end
      if (first_f < 0 && readdata[3:0] == 4'hF) first_f = k;
    end
    idle();
    checks++; if (first_f != 10) begin failures++; $display("FAIL reset_data_latency got=%0d exp=10", first_f); end
    do_read(2'd3, d);
    checks++; if (d !== 32'hF) begin failures++; $display("FAIL reset_edgecap got=%h exp=f", d); end
  endtask

  task automatic test_glitch();
    logic [31:0] d;
    int first_k;
    reset = 1; in_port = 4'h0;
    repeat (2) step();
    reset = 0;
    repeat (12) step();
    in_port = 4'h2; repeat (4) step();
    in_port = 4'h0; repeat (5) step();
    in_port = 4'h2;
    first_k = -1;
    for (int k = 0; k < 15; k++) begin
      cs = 1; read = 1; address = 2'd0;
      step();
      checks++; if (readdata !== m_rd) begin failures++; $display("FAIL glitch_data_k%0d got=%h exp=%h", k, readdata, m_rd); end
      if (first_k < 0 && readdata[1]) first_k = k;
    end
    idle();
    checks++; if (first_k != 10) begin failures++; $display("FAIL glitch_latency got=%0d exp=10", first_k); end
    do_read(2'd3, d);
    checks++; if (d !== 32'h2) begin failures++; $display("FAIL glitch_edgecap got=%h exp=2", d); end
  endtask

  task automatic test_irq();
    logic [31:0] d;
    int first_j;
    do_write(2'd3, 32'hF);
    do_write(2'd1, 32'h2);
    in_port = 4'h0; repeat (12) step();
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_fall_no_irq got=%b exp=0", irq); end
    in_port = 4'h2;
    first_j = -1;
    for (int j = 0; j < 14; j++) begin
      step();
      checks++; if (irq !== m_irq) begin failures++; $display("FAIL irq_rise_j%0d got=%b exp=%b", j, irq, m_irq); end
      if (first_j < 0 && irq) first_j = j;
    end
    if (IRQ_EN) begin
      checks++; if (first_j != 10) begin failures++; $display("FAIL irq_latency got=%0d exp=10", first_j); end
    end
    do_write(2'd3, 32'h0);
    do_read(2'd3, d);
    checks++; if (d !== 32'h2) begin failures++; $display("FAIL irq_w0_edgecap got=%h exp=2", d); end
    checks++; if (irq !== IRQ_EN) begin failures++; $display("FAIL irq_w0_irq got=%b exp=%b", irq, IRQ_EN); end
    do_write(2'd3, 32'h2);
    checks++; if (irq !== IRQ_EN) begin failures++; $display("FAIL irq_clr_lag got=%b exp=%b", irq, IRQ_EN); end
    step();
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_clr got=%b exp=0", irq); end
  endtask

  task automatic test_w1c_collision();
    logic [31:0] d;
    do_write(2'd3, 32'hF);
    in_port = 4'h3;
    repeat (9) step();
    cs = 1; write = 1; address = 2'd3; writedata = 32'h1;
    step();
    idle();
    do_read(2'd3, d);
    checks++; if (d !== m_rd) begin failures++; $display("FAIL w1c_collision_model got=%h exp=%h", d, m_rd); end
    checks++; if (d !== 32'h1) begin failures++; $display("FAIL w1c_collision got=%h exp=1", d); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic [31:0] exp_v [4];
    exp_v[0] = 32'h3; exp_v[1] = IRQ_EN ? 32'h2 : 32'h0; exp_v[2] = 32'h3; exp_v[3] = 32'h1;
    for (int a = 0; a < 4; a++) begin
      cs = 1; read = 1; address = 2'(a);
      step();
      checks++; if (readdata !== exp_v[a]) begin failures++; $display("FAIL b2b_addr%0d got=%h exp=%h", a, readdata, exp_v[a]); end
      checks++; if (readdata !== m_rd) begin failures++; $display("FAIL b2b_model%0d got=%h exp=%h", a, readdata, m_rd); end
    end
    idle();
    do_write(2'd0, 32'hFFFF_FFFF);
    do_write(2'd2, 32'hFFFF_FFFC);
    do_read(2'd0, d);
    checks++; if (d !== 32'h3) begin failures++; $display("FAIL wr_ro_data got=%h exp=3", d); end
    cs = 1; read = 1; write = 1; address = 2'd1; writedata = 32'hF;
    step();
    idle();
    checks++; if (readdata !== exp_v[1]) begin failures++; $display("FAIL rw_same got=%h exp=%h", readdata, exp_v[1]); end
    do_read(2'd1, d);
    checks++; if (d !== (IRQ_EN ? 32'hF : 32'h0)) begin failures++; $display("FAIL mask_readback got=%h exp=%h", d, IRQ_EN ? 32'hF : 32'h0); end
  endtask

  task automatic test_all_edges();
    logic [31:0] d;
    in_port = 4'h0; repeat (12) step();
    do_write(2'd3, 32'hF);
    in_port = 4'hF; repeat (12) step();
    do_read(2'd3, d);
    checks++; if (d !== 32'hF) begin failures++; $display("FAIL all_edgecap got=%h exp=f", d); end
    checks++; if (irq !== IRQ_EN) begin failures++; $display("FAIL all_irq got=%b exp=%b", irq, IRQ_EN); end
  endtask

  task automatic test_random();
    int r;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 11) == 0) in_port = in_port ^ 4'($urandom_range(1, 15));
      r = $urandom_range(0, 9);
      idle();
      if (r < 4) begin
        cs = 1; read = 1; address = 2'($urandom_range(0, 3));
      end else if (r == 4) begin
        cs = 1; write = 1; address = 2'($urandom_range(0, 3)); writedata = $urandom;
      end
      step();
      if (r < 4) begin
        checks++; if (readdata !== m_rd) begin failures++; $display("FAIL rand_read_n%0d got=%h exp=%h", n, readdata, m_rd); end
      end
      checks++; if (irq !== m_irq) begin failures++; $display("FAIL rand_irq_n%0d got=%b exp=%b", n, irq, m_irq); end
    end
    idle();
  endtask

  initial begin
    idle();
    reset = 1; in_port = '0;
    test_reset();
    test_glitch();
    test_irq();
    test_w1c_collision();
    test_back_to_back();
    test_all_edges();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
